// File: rtl/alu_issue_queue_pkg.sv
// Shared constants and helpers for the ALU reservation station.
package rs_pkg;

  // Tag value that marks an operand as already holding its value.
  localparam int TAG_FREE = 0;
  // Opcode presented while no issue is pending.
  localparam int NOP = 0;

  // Lowest set bit index (-1 if none). Gives the CDB snoop priority
  // (lowest port wins on duplicate tags) and picks the free slot.
  function automatic int first_set(input logic [31:0] v);
    first_set = -1;
    for (int i = 31; i >= 0; i--)
      if (v[i]) first_set = i;
  endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatcher / CDB / branch unit / ALU connections of the issue queue.
interface alu_issue_queue_if #(
  parameter int CDB_N  = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 6,
  parameter int BTAG_W = 4
);
  localparam int BN_W = (BTAG_W > 1) ? $clog2(BTAG_W) : 1;

  logic                    rdy;
  logic [CDB_N-1:0]        cdb_en;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*DATA_W-1:0] cdb_data;
  logic                    alloc_en;
  logic [OP_W-1:0]         alloc_op;
  logic [DATA_W-1:0]       alloc_opnd_o, alloc_opnd_t, alloc_pc;
  logic [TAG_W-1:0]        alloc_tag_o, alloc_tag_t, alloc_tag_w;
  logic [BTAG_W-1:0]       alloc_btag;
  logic                    alloc_ready;
  logic                    iss_valid;
  logic [OP_W-1:0]         iss_op;
  logic [DATA_W-1:0]       iss_opnd_o, iss_opnd_t, iss_pc;
  logic [TAG_W-1:0]        iss_tag_w;
  logic [BTAG_W-1:0]       iss_btag;
  logic                    b_free_en, mis_taken;
  logic [BN_W-1:0]         b_free_num;

  modport master (
    output rdy, cdb_en, cdb_tag, cdb_data, alloc_en, alloc_op, alloc_opnd_o,
           alloc_opnd_t, alloc_pc, alloc_tag_o, alloc_tag_t, alloc_tag_w,
           alloc_btag, b_free_en, mis_taken, b_free_num,
    input  alloc_ready, iss_valid, iss_op, iss_opnd_o, iss_opnd_t, iss_pc,
           iss_tag_w, iss_btag
  );
  modport slave (
    input  rdy, cdb_en, cdb_tag, cdb_data, alloc_en, alloc_op, alloc_opnd_o,
           alloc_opnd_t, alloc_pc, alloc_tag_o, alloc_tag_t, alloc_tag_w,
           alloc_btag, b_free_en, mis_taken, b_free_num,
    output alloc_ready, iss_valid, iss_op, iss_opnd_o, iss_opnd_t, iss_pc,
           iss_tag_w, iss_btag
  );
endinterface

// File: rtl/alu_issue_queue_entry.sv
// One reservation-station slot: operand wakeup, branch-mask update, squash.
module rs_entry import rs_pkg::*; #(
  parameter int CDB_N  = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 6,
  parameter int BTAG_W = 4,
  parameter int BN_W   = 2
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [CDB_N-1:0]        cdb_en,
  input  logic [CDB_N*TAG_W-1:0]  cdb_tag,
  input  logic [CDB_N*DATA_W-1:0] cdb_data,
  input  logic                    br_en,
  input  logic                    br_mis,
  input  logic [BN_W-1:0]         br_num,
  input  logic                    wr,
  input  logic [OP_W-1:0]         wr_op,
  input  logic [DATA_W-1:0]       wr_o,
  input  logic [DATA_W-1:0]       wr_t,
  input  logic [TAG_W-1:0]        wr_tag_o,
  input  logic [TAG_W-1:0]        wr_tag_t,
  input  logic [TAG_W-1:0]        wr_tag_w,
  input  logic [DATA_W-1:0]       wr_pc,
  input  logic [BTAG_W-1:0]       wr_btag,
  input  logic                    clr,
  output logic                    vld,
  output logic                    ready,
  output logic                    kill,
  output logic [OP_W-1:0]         out_op,
  output logic [DATA_W-1:0]       out_o,
  output logic [DATA_W-1:0]       out_t,
  output logic [TAG_W-1:0]        out_tag_w,
  output logic [DATA_W-1:0]       out_pc,
  output logic [BTAG_W-1:0]       out_btag
);
  logic [DATA_W-1:0] o, t;
  logic [TAG_W-1:0]  tag_o, tag_t, tag_o_n, tag_t_n;
  logic [BTAG_W-1:0] btag;
  logic [CDB_N-1:0]  hit_o, hit_t;
  int                io, it;

  // Snoop the CDB this cycle so a woken entry can issue on the same edge.
  always_comb begin
    hit_o = '0;
    hit_t = '0;
    for (int k = 0; k < CDB_N; k++) begin
      hit_o[k] = cdb_en[k] && cdb_tag[k*TAG_W +: TAG_W] == tag_o && tag_o != TAG_W'(TAG_FREE);
      hit_t[k] = cdb_en[k] && cdb_tag[k*TAG_W +: TAG_W] == tag_t && tag_t != TAG_W'(TAG_FREE);
    end
    io = first_set(32'(hit_o));
    it = first_set(32'(hit_t));
    out_o   = o;
    out_t   = t;
    tag_o_n = tag_o;
    tag_t_n = tag_t;
    for (int k = 0; k < CDB_N; k++) begin
      if (k == io) begin out_o = cdb_data[k*DATA_W +: DATA_W]; tag_o_n = '0; end
      if (k == it) begin out_t = cdb_data[k*DATA_W +: DATA_W]; tag_t_n = '0; end
    end
    out_btag = btag;
    if (br_en && !br_mis) out_btag[br_num] = 1'b0;
  end

  assign kill  = vld && br_en && br_mis && btag[br_num];
  assign ready = vld && !kill && tag_o_n == '0 && tag_t_n == '0;

  // Slot state: load on alloc, empty on issue/squash, else track wakeups.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0; out_op <= '0; o <= '0; t <= '0; tag_o <= '0; tag_t <= '0;
      out_tag_w <= '0; out_pc <= '0; btag <= '0;
    end else if (rdy) begin
      if (wr) begin
        vld <= 1'b1; out_op <= wr_op; o <= wr_o; t <= wr_t;
        tag_o <= wr_tag_o; tag_t <= wr_tag_t; out_tag_w <= wr_tag_w;
        out_pc <= wr_pc; btag <= wr_btag;
      end else if (vld && (clr || kill)) begin
        vld <= 1'b0; tag_o <= '0; tag_t <= '0;
      end else begin
        o <= out_o; t <= out_t; tag_o <= tag_o_n; tag_t <= tag_t_n; btag <= out_btag;
      end
    end
  end
endmodule

// File: rtl/alu_issue_queue.sv
// ALU reservation station: free-slot pick, age matrix, oldest-ready issue, bypass.
module alu_issue_queue import rs_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int CDB_N  = 2,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 5,
  parameter int OP_W   = 6,
  parameter int BTAG_W = 4
)(
  input logic clk,
  input logic rst,
  alu_issue_queue_if.slave bus
);
  localparam int BN_W = (BTAG_W > 1) ? $clog2(BTAG_W) : 1;

  logic [DEPTH-1:0]            vld, ready, kill, sel, gone, wr_oh;
  logic [DEPTH-1:0][DEPTH-1:0] age;
  logic [OP_W-1:0]             e_op     [DEPTH];
  logic [DATA_W-1:0]           e_o      [DEPTH];
  logic [DATA_W-1:0]           e_t      [DEPTH];
  logic [TAG_W-1:0]            e_tag_w  [DEPTH];
  logic [DATA_W-1:0]           e_pc     [DEPTH];
  logic [BTAG_W-1:0]           e_btag   [DEPTH];

  logic [CDB_N-1:0]  a_hit_o, a_hit_t;
  logic [DATA_W-1:0] a_o, a_t;
  logic [TAG_W-1:0]  a_tag_o, a_tag_t;
  logic [BTAG_W-1:0] a_btag;
  logic              a_kill, alloc_ok, any_rdy, bypass, write;
  int                a_io, a_it, fidx;

  logic [OP_W-1:0]   s_op;
  logic [DATA_W-1:0] s_o, s_t, s_pc;
  logic [TAG_W-1:0]  s_tag_w;
  logic [BTAG_W-1:0] s_btag;

  assign bus.alloc_ready = !(&vld);

  // Alloc operands snoop the CDB too; decide bypass vs. slot write.
  always_comb begin
    a_hit_o = '0;
    a_hit_t = '0;
    for (int k = 0; k < CDB_N; k++) begin
      a_hit_o[k] = bus.cdb_en[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == bus.alloc_tag_o
                   && bus.alloc_tag_o != TAG_W'(TAG_FREE);
      a_hit_t[k] = bus.cdb_en[k] && bus.cdb_tag[k*TAG_W +: TAG_W] == bus.alloc_tag_t
                   && bus.alloc_tag_t != TAG_W'(TAG_FREE);
    end
    a_io    = first_set(32'(a_hit_o));
    a_it    = first_set(32'(a_hit_t));
    a_o     = bus.alloc_opnd_o;
    a_t     = bus.alloc_opnd_t;
    a_tag_o = bus.alloc_tag_o;
    a_tag_t = bus.alloc_tag_t;
    for (int k = 0; k < CDB_N; k++) begin
      if (k == a_io) begin a_o = bus.cdb_data[k*DATA_W +: DATA_W]; a_tag_o = '0; end
      if (k == a_it) begin a_t = bus.cdb_data[k*DATA_W +: DATA_W]; a_tag_t = '0; end
    end
    a_btag = bus.alloc_btag;
    if (bus.b_free_en && !bus.mis_taken) a_btag[bus.b_free_num] = 1'b0;
    a_kill   = bus.b_free_en && bus.mis_taken && bus.alloc_btag[bus.b_free_num];
    alloc_ok = bus.alloc_en && bus.alloc_ready && !a_kill;
    any_rdy  = |ready;
    bypass   = alloc_ok && !any_rdy && a_tag_o == '0 && a_tag_t == '0;
    write    = alloc_ok && !bypass;
    fidx     = first_set(32'(~vld));
    for (int i = 0; i < DEPTH; i++) wr_oh[i] = write && i == fidx;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_entry #(.CDB_N(CDB_N), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W),
               .BTAG_W(BTAG_W), .BN_W(BN_W)) u_ent (
      .clk(clk), .rst(rst), .rdy(bus.rdy),
      .cdb_en(bus.cdb_en), .cdb_tag(bus.cdb_tag), .cdb_data(bus.cdb_data),
      .br_en(bus.b_free_en), .br_mis(bus.mis_taken), .br_num(bus.b_free_num),
      .wr(wr_oh[g]), .wr_op(bus.alloc_op), .wr_o(a_o), .wr_t(a_t),
      .wr_tag_o(a_tag_o), .wr_tag_t(a_tag_t), .wr_tag_w(bus.alloc_tag_w),
      .wr_pc(bus.alloc_pc), .wr_btag(a_btag), .clr(sel[g]),
      .vld(vld[g]), .ready(ready[g]), .kill(kill[g]),
      .out_op(e_op[g]), .out_o(e_o[g]), .out_t(e_t[g]), .out_tag_w(e_tag_w[g]),
      .out_pc(e_pc[g]), .out_btag(e_btag[g])
    );
  end

  // Oldest ready entry: ready and older than every other ready entry (one-hot).
  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = ready[i];
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && !age[i][j]) sel[i] = 1'b0;
    end
    gone = sel | kill;
  end

  // Issue operand mux over the one-hot select.
  always_comb begin
    s_op = '0; s_o = '0; s_t = '0; s_tag_w = '0; s_pc = '0; s_btag = '0;
    for (int i = 0; i < DEPTH; i++)
      if (sel[i]) begin
        s_op = e_op[i]; s_o = e_o[i]; s_t = e_t[i];
        s_tag_w = e_tag_w[i]; s_pc = e_pc[i]; s_btag = e_btag[i];
      end
  end

  // Age matrix: new entry younger than all survivors; freed rows/cols cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) age <= '0;
    else if (bus.rdy)
      for (int i = 0; i < DEPTH; i++)
        for (int j = 0; j < DEPTH; j++)
          if (wr_oh[i])               age[i][j] <= 1'b0;
          else if (wr_oh[j])          age[i][j] <= vld[i] && !gone[i];
          else if (gone[i] || gone[j]) age[i][j] <= 1'b0;
  end

  // Issue register: queued oldest-ready first, else bypassed alloc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.iss_valid <= 1'b0; bus.iss_op <= OP_W'(NOP); bus.iss_opnd_o <= '0;
      bus.iss_opnd_t <= '0; bus.iss_tag_w <= '0; bus.iss_pc <= '0; bus.iss_btag <= '0;
    end else if (bus.rdy) begin
      if (any_rdy) begin
        bus.iss_valid <= 1'b1; bus.iss_op <= s_op; bus.iss_opnd_o <= s_o;
        bus.iss_opnd_t <= s_t; bus.iss_tag_w <= s_tag_w; bus.iss_pc <= s_pc;
        bus.iss_btag <= s_btag;
      end else if (bypass) begin
        bus.iss_valid <= 1'b1; bus.iss_op <= bus.alloc_op; bus.iss_opnd_o <= a_o;
        bus.iss_opnd_t <= a_t; bus.iss_tag_w <= bus.alloc_tag_w; bus.iss_pc <= bus.alloc_pc;
        bus.iss_btag <= a_btag;
      end else begin
        bus.iss_valid <= 1'b0;
        if (bus.b_free_en && !bus.mis_taken) bus.iss_btag[bus.b_free_num] <= 1'b0;
      end
    end
  end

  // Dispatcher must not push into a full queue.
  always_ff @(posedge clk) begin
    if (!rst && bus.rdy && bus.alloc_en)
      assert (bus.alloc_ready) else $error("alloc_en while queue full, request dropped");
  end
endmodule
